alu_request_frontend: RTL and testbench
=======================================

// Module: alu_request_frontend
// PURPOSE
//   Command front-end upstream of the ALU sequencer. Accepts operation requests (op, A, B) on a
//   valid/ready port, queues them, and launches one ALU operation at a time. A launch is a
//   one-cycle begin_signal pulse with op/operands held stable until end_signal. On completion it
//   captures the 2W-bit datapath result and returns it on a valid/ready response port. It also
//   screens illegal ops and divide-by-zero, and times out a hung operation.
// PARAMETERS
//   W        8   operand width (the sequencer iterates W times for MUL/DIV)
//   DEPTH    2   request FIFO entries (power of 2, >=2)
//   TIMEOUT  64  cycles from begin_signal to forced timeout response
// PORTS
//   clk           in   1    clock, all state on rising edge
//   reset         in   1    synchronous reset, active-low
//   req_valid     in   1    request present
//   req_ready     out  1    FIFO not full
//   req_op        in   3    000 AND,001 OR,010 XOR,011 ADD,100 SUB,101 MUL,110 DIV,111 illegal
//   req_a/req_b   in   W    operands (DIV: a dividend, b divisor)
//   alu_op        out  3    op to sequencer/datapath, held from launch to next launch
//   alu_a/alu_b   out  W    operands to datapath, held likewise
//   begin_signal  out  1    one-cycle launch pulse
//   end_signal    in   1    completion pulse from sequencer (registered there)
//   alu_result    in   2W   datapath result {hi,lo}; valid in the end_signal cycle
//   rsp_valid     out  1    response present
//   rsp_ready     in   1    consumer accepts response
//   rsp_data      out  2W   result; 0 on error
//   rsp_err       out  2    00 ok, 01 illegal op, 10 timeout, 11 divide-by-zero
//   busy          out  1    state != IDLE or FIFO non-empty
// BEHAVIOUR
//   Reset (reset==0 at edge): FIFO emptied; state IDLE. Outputs: begin_signal, rsp_valid,
//     rsp_data, rsp_err, alu_op, alu_a, alu_b and busy are 0; req_ready is 1.
//   FIFO: push on req_valid&req_ready. Push and pop in the same cycle are legal when full.
//     Pointers wrap modulo DEPTH. Requests are served strictly in order.
//   FSM (registered): IDLE, LAUNCH, WAIT, RESP.
//     IDLE: if FIFO non-empty, pop head. On illegal op or (DIV & b==0): load rsp_err,
//       rsp_data=0, go to RESP (no begin_signal). Otherwise register alu_op/a/b and go to LAUNCH.
//     LAUNCH: begin_signal=1 for exactly this cycle; clear watchdog; go to WAIT.
//     WAIT: on end_signal: rsp_data<=alu_result, rsp_err<=00, go to RESP.
//       Else if watchdog==TIMEOUT-1: rsp_err<=10, rsp_data<=0, go to RESP.
//       A simultaneous end_signal and expiry resolves as completion.
//     RESP: rsp_valid=1, data stable until rsp_ready; on handshake go to IDLE.
//   One operation is outstanding at a time. No launch while a response is unaccepted.
//   end_signal outside WAIT is ignored (includes a late pulse after a timeout).
//   Latency: push in cycle t into an empty FIFO while IDLE -> pop in t+1 -> begin_signal in t+2.
//     Earliest rsp_valid is the cycle after end_signal.
//   Reset mid-operation (any state) returns to the reset values above; queued requests are
//     discarded. The sequencer shares this reset.
//   Widths: watchdog is clog2(TIMEOUT)+1 bits, saturating; FIFO count is clog2(DEPTH)+1 bits.
// STRUCTURE
//   alu_pkg: op code localparams (OP_AND..OP_DIV, OP_ILL), rsp_err codes, state encoding.
//   Sub-module alu_req_fifo: parameterised sync FIFO (W*2+3 bit entries, full/empty/count).
//   Top: FSM, operand/result registers, watchdog counter.
// TESTING (bench pairs DUT with a sequencer model: end_signal N cycles after begin_signal)
//   1. reset held low 2 cycles mid-stream -> all outputs 0, req_ready=1, busy=0.
//   2. ADD a=0x05 b=0x03, model N=12 returns 0x0008 -> begin_signal 1 cycle at t+2, alu_op=011;
//      rsp_data=0x0008, rsp_err=00.
//   3. MUL 0x0C*0x0B then DIV 0x64/0x07 back-to-back, rsp_ready low 10 cycles -> 0x0084 held
//      until accepted; then {rem 0x02, quot 0x0E}; second begin only after first handshake.
//   4. 4 requests pushed in 4 consecutive cycles, DEPTH=2 -> req_ready drops after FIFO fills;
//      no request lost or reordered.
//   5. op=111, then DIV b=0 -> rsp_err=01 then 11, rsp_data=0, begin_signal never asserted.
//   6. model never ends, TIMEOUT=64 -> rsp_err=10 at 64 cycles after begin; late end_signal
//      ignored; reset asserted in WAIT -> IDLE next cycle, FIFO empty.

Source files
------------

// File: rtl/alu_request_frontend_pkg.sv
// Shared op codes, response error codes and FSM encoding for the ALU request front-end.
package alu_request_frontend_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILL     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_DIV0    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Screens a request before launch; ERR_OK means it may go to the sequencer.
    function automatic logic [1:0] screen_err(input logic [2:0] op, input logic b_is_zero);
        if (op == OP_ILL) begin
            return ERR_ILL;
        end
        if ((op == OP_DIV) && b_is_zero) begin
            return ERR_DIV0;
        end
        return ERR_OK;
    endfunction

endpackage

// File: rtl/alu_request_frontend_if.sv
// Request, sequencer and response signals of the ALU front-end.
interface alu_request_frontend_if #(
    parameter int unsigned W = 8
);
    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           begin_signal;
    logic           end_signal;
    logic [2*W-1:0] alu_result;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic [1:0]     rsp_err;
    logic           busy;

    modport master (
        output req_valid, req_op, req_a, req_b, end_signal, alu_result, rsp_ready,
        input  req_ready, alu_op, alu_a, alu_b, begin_signal, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, end_signal, alu_result, rsp_ready,
        output req_ready, alu_op, alu_a, alu_b, begin_signal, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_request_frontend_fifo.sv
// Synchronous FIFO holding queued {op, a, b} requests; accepts push when full if popping.
module alu_request_frontend_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];

    // Storage array, no reset needed since cnt gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/alu_request_frontend.sv
// Queues ALU requests, launches one operation at a time, screens errors and times out hangs.
module alu_request_frontend
    import alu_request_frontend_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_request_frontend_if.slave bus
);
    localparam int unsigned ENTRY_W = 2 * W + 3;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned WD_W    = $clog2(TIMEOUT) + 1;

    logic               push_c;
    logic               pop_c;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head;
    logic [2:0]         head_op;
    logic [W-1:0]       head_a;
    logic [W-1:0]       head_b;
    logic [1:0]         head_err_c;

    state_t             state_q, state_d;
    logic               begin_q, begin_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0]     rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_err_q, rsp_err_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [W-1:0]       alu_a_q, alu_a_d;
    logic [W-1:0]       alu_b_q, alu_b_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;

    assign push_c = bus.req_valid && !fifo_full;

    alu_request_frontend_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .wdata ({bus.req_op, bus.req_a, bus.req_b}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_op, head_a, head_b} = head;
    assign head_err_c = screen_err(head_op, head_b == '0);

    // Next-state and next-output logic for the launch/wait/response sequence.
    always_comb begin
        state_d     = state_q;
        pop_c       = 1'b0;
        begin_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        wdog_d      = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c = 1'b1;
                    if (head_err_c != ERR_OK) begin
                        rsp_err_d   = head_err_c;
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        alu_op_d = head_op;
                        alu_a_d  = head_a;
                        alu_b_d  = head_b;
                        begin_d  = 1'b1;
                        state_d  = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over a coincident watchdog expiry.
                if (bus.end_signal) begin
                    rsp_data_d  = bus.alu_result;
                    rsp_err_d   = ERR_OK;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (wdog_q != {WD_W{1'b1}}) begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            begin_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            begin_q     <= begin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            wdog_q      <= wdog_d;
        end
    end

    assign bus.req_ready    = !fifo_full;
    assign bus.busy         = (state_q != ST_IDLE) || (fifo_count != '0);
    assign bus.begin_signal = begin_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
endmodule

// File: tb/tb_alu_request_frontend.sv
// Directed bench for alu_request_frontend with a fixed-latency sequencer model.
module tb_alu_request_frontend;
    import alu_request_frontend_pkg::*;

    logic clk;
    logic reset;
    alu_request_frontend_if #(.W(8)) bus ();

    alu_request_frontend #(.W(8), .DEPTH(2), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    int         begin_cnt = 0;
    int         rsp_n     = 0;
    logic [17:0] rsp_log [16];
    bit         saw_full;
    int         model_n;
    bit         model_hang;
    logic       model_end;
    logic       man_end;
    bit         model_pend;
    int         model_k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference datapath: what the sequencer returns for the held op/operands.
    function automatic logic [15:0] model_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_AND:  return {8'h00, a & b};
            OP_OR:   return {8'h00, a | b};
            OP_XOR:  return {8'h00, a ^ b};
            OP_ADD:  return 16'(a) + 16'(b);
            OP_SUB:  return 16'(a) - 16'(b);
            OP_MUL:  return 16'(a) * 16'(b);
            OP_DIV:  return (b == 8'h00) ? 16'h0000 : {a % b, a / b};
            default: return 16'h0000;
        endcase
    endfunction

    assign bus.alu_result = model_res(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.end_signal = model_end | man_end;

    // Sequencer model: end_signal model_n cycles after begin_signal.
    always @(posedge clk) begin
        if (!reset) begin
            model_end  <= 1'b0;
            model_pend <= 1'b0;
            model_k    <= 0;
        end else begin
            model_end <= 1'b0;
            if (model_pend) begin
                if (model_k == model_n - 1) begin
                    model_end  <= 1'b1;
                    model_pend <= 1'b0;
                end else begin
                    model_k <= model_k + 1;
                end
            end else if (bus.begin_signal && !model_hang) begin
                model_pend <= 1'b1;
                model_k    <= 1;
            end
        end
    end

    // Response log and launch counter.
    always @(posedge clk) begin
        if (reset && bus.rsp_valid && bus.rsp_ready) begin
            rsp_log[rsp_n[3:0]] <= {bus.rsp_err, bus.rsp_data};
            rsp_n <= rsp_n + 1;
        end
        if (bus.begin_signal) begin
            begin_cnt <= begin_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_begin"}, 32'(bus.begin_signal), 0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        check({tag, "_alu_op"}, 32'(bus.alu_op), 0);
        check({tag, "_alu_ab"}, 32'({bus.alu_a, bus.alu_b}), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 1);
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int k = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        while (!bus.req_ready && k < 200) begin
            saw_full = 1'b1;
            tick();
            k++;
        end
        if (k >= 200) check("push_stalled", 32'(k), 0);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int bound);
        int k = 0;
        while (!bus.rsp_valid && k < bound) begin
            tick();
            k++;
        end
        check(tag, 32'(bus.rsp_valid), 1);
    endtask

    task automatic wait_begin(input string tag);
        int k = 0;
        while (!bus.begin_signal && k < 20) begin
            tick();
            k++;
        end
        check(tag, 32'(bus.begin_signal), 1);
    endtask

    task automatic wait_log(input string tag, input int target);
        int k = 0;
        while (rsp_n < target && k < 400) begin
            tick();
            k++;
        end
        check(tag, 32'(rsp_n >= target), 1);
    endtask

    initial begin
        int  base;
        int  bc;
        bit  hold_bad;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'b000;
        bus.req_a      = 8'h00;
        bus.req_b      = 8'h00;
        bus.rsp_ready  = 1'b0;
        man_end        = 1'b0;
        model_n        = 12;
        model_hang     = 1'b0;
        saw_full       = 1'b0;

        // Power-on reset.
        repeat (2) tick();
        check_reset("rst0");
        reset = 1'b1;
        tick();

        // Reset held two cycles while an ADD is in flight.
        push(OP_ADD, 8'h05, 8'h03);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        check_reset("rst_mid");
        reset = 1'b1;
        tick();

        // ADD latency and result.
        bus.req_valid = 1'b1;
        bus.req_op    = OP_ADD;
        bus.req_a     = 8'h05;
        bus.req_b     = 8'h03;
        check("add_ready", 32'(bus.req_ready), 1);
        tick();
        bus.req_valid = 1'b0;
        check("add_t1_begin", 32'(bus.begin_signal), 0);
        check("add_t1_busy", 32'(bus.busy), 1);
        tick();
        check("add_t2_begin", 32'(bus.begin_signal), 1);
        check("add_alu_op", 32'(bus.alu_op), 32'(3'b011));
        check("add_alu_ab", 32'({bus.alu_a, bus.alu_b}), 32'h0503);
        tick();
        check("add_t3_begin", 32'(bus.begin_signal), 0);
        repeat (11) tick();
        check("add_rsp_early", 32'(bus.rsp_valid), 0);
        tick();
        check("add_rsp_valid", 32'(bus.rsp_valid), 1);
        check("add_rsp_data", 32'(bus.rsp_data), 32'h0008);
        check("add_rsp_err", 32'(bus.rsp_err), 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("add_rsp_done", 32'(bus.rsp_valid), 0);

        // MUL then DIV back-to-back with a stalled consumer.
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MUL;
        bus.req_a     = 8'h0C;
        bus.req_b     = 8'h0B;
        tick();
        bus.req_op    = OP_DIV;
        bus.req_a     = 8'h64;
        bus.req_b     = 8'h07;
        tick();
        bus.req_valid = 1'b0;
        check("mul_begin", 32'(bus.begin_signal), 1);
        check("mul_alu_op", 32'(bus.alu_op), 32'(OP_MUL));
        wait_rsp("mul_rsp_seen", 40);
        hold_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.rsp_valid || bus.rsp_data !== 16'h0084 || bus.begin_signal) hold_bad = 1'b1;
        end
        check("mul_hold", 32'(hold_bad), 0);
        check("mul_rsp_data", 32'(bus.rsp_data), 32'h0084);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("div_no_begin_yet", 32'(bus.begin_signal), 0);
        tick();
        check("div_begin", 32'(bus.begin_signal), 1);
        check("div_alu", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'({OP_DIV, 8'h64, 8'h07}));
        wait_rsp("div_rsp_seen", 40);
        check("div_rsp_data", 32'(bus.rsp_data), 32'h020E);
        check("div_rsp_err", 32'(bus.rsp_err), 0);
        bus.rsp_ready = 1'b1;
        tick();

        // Four requests in consecutive cycles into a two-entry FIFO.
        base     = rsp_n;
        saw_full = 1'b0;
        push(OP_AND, 8'hF0, 8'h3C);
        push(OP_OR,  8'hF0, 8'h0F);
        push(OP_XOR, 8'hAA, 8'hFF);
        push(OP_SUB, 8'h10, 8'h01);
        check("burst_full_seen", 32'(saw_full), 1);
        wait_log("burst_all_rsp", base + 4);
        check("burst_rsp0", 32'(rsp_log[4'(base + 0)]), 32'h00030);
        check("burst_rsp1", 32'(rsp_log[4'(base + 1)]), 32'h000FF);
        check("burst_rsp2", 32'(rsp_log[4'(base + 2)]), 32'h00055);
        check("burst_rsp3", 32'(rsp_log[4'(base + 3)]), 32'h0000F);

        // Illegal op and divide-by-zero never reach the sequencer.
        base = rsp_n;
        bc   = begin_cnt;
        push(OP_ILL, 8'h01, 8'h02);
        push(OP_DIV, 8'h10, 8'h00);
        wait_log("reject_all_rsp", base + 2);
        check("reject_ill", 32'(rsp_log[4'(base + 0)]), 32'({ERR_ILL, 16'h0000}));
        check("reject_div0", 32'(rsp_log[4'(base + 1)]), 32'({ERR_DIV0, 16'h0000}));
        tick();
        check("reject_no_begin", 32'(begin_cnt - bc), 0);
        bus.rsp_ready = 1'b0;

        // Hung sequencer: watchdog expiry, late end ignored.
        model_hang = 1'b1;
        push(OP_ADD, 8'h01, 8'h02);
        wait_begin("to_begin");
        repeat (64) tick();
        check("to_early", 32'(bus.rsp_valid), 0);
        tick();
        check("to_rsp_valid", 32'(bus.rsp_valid), 1);
        check("to_rsp_err", 32'(bus.rsp_err), 32'(ERR_TIMEOUT));
        check("to_rsp_data", 32'(bus.rsp_data), 0);
        man_end = 1'b1;
        tick();
        man_end = 1'b0;
        check("late_end_resp", 32'({bus.rsp_valid, bus.rsp_err}), 32'({1'b1, ERR_TIMEOUT}));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bc = begin_cnt;
        man_end = 1'b1;
        tick();
        man_end = 1'b0;
        tick();
        check("late_end_idle", 32'({bus.rsp_valid, bus.busy}), 0);

        // Reset while waiting discards the queued request.
        push(OP_AND, 8'h01, 8'h01);
        push(OP_OR,  8'h02, 8'h02);
        wait_begin("rstw_begin");
        repeat (2) tick();
        check("rstw_busy", 32'(bus.busy), 1);
        reset = 1'b0;
        tick();
        check("rstw_idle", 32'({bus.busy, bus.req_ready, bus.begin_signal}), 32'(3'b010));
        check("rstw_alu_op", 32'(bus.alu_op), 0);
        reset = 1'b1;
        bc = begin_cnt;
        repeat (6) tick();
        check("rstw_flushed", 32'(begin_cnt - bc), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
